// File: rtl/prime_pkg.sv
// Shared constants for the prime-gap logger: default bus width, FIFO depth and the twin-prime gap.
package prime_pkg;
  localparam int NW_DEFAULT    = 10;
  localparam int DEPTH_DEFAULT = 16;
  localparam int TWIN_GAP      = 2;
endpackage

// File: rtl/prime_fifo.sv
// First-word-fall-through FIFO (DEPTH x W); write visible on rd_dat one cycle after acceptance.
// Backpressure: a write is refused when full unless a read pops in the same cycle; rd_dat reads 0 while empty.
module prime_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 10
) (
  input  logic                     core_clk,
  input  logic                     arst_n,
  input  logic                     clr,
  input  logic                     wr_vld,
  input  logic [W-1:0]             wr_dat,
  input  logic                     rd_rdy,
  output logic [W-1:0]             rd_dat,
  output logic                     rd_vld,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          wr_acc;

  assign rd_vld = (count != '0);
  assign full   = (count == DEPTH_C);
  assign do_pop = rd_rdy && rd_vld;
  // Popping while full frees the slot the simultaneous write lands in.
  assign wr_acc = wr_vld && (!full || do_pop);
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge core_clk) begin
    if (wr_acc && !clr) mem[wr_ptr] <= wr_dat;
  end
endmodule

// File: rtl/prime_gap_log.sv
// Logs distinct primes into a FWFT FIFO (1-cycle latency) and tracks last/max gap; full FIFO drops and sets Overflow.
// Optional twin-prime counter enabled by macro PRIME_GAP_TWIN_COUNT_EN.
module prime_gap_log
  import prime_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int NW    = NW_DEFAULT
) (
  input  logic                   SysClk,
  input  logic                   Reset,
  input  logic                   Prime,
  input  logic [NW-1:0]          NumberChecked,
  input  logic                   Clear,
  input  logic                   RdReq,
  output logic [NW-1:0]          RdData,
  output logic                   RdValid,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Overflow,
  output logic [NW-1:0]          LastGap,
  output logic [NW-1:0]          MaxGap
`ifdef PRIME_GAP_TWIN_COUNT_EN
  ,
  output logic [7:0]             TwinCount
`endif
);
  logic [NW-1:0] prev;
  logic          prev_vld;
  logic          capture;
  logic [NW-1:0] gap;
  logic          full;
  logic          do_pop;

  // A held Prime for the same number captures once; a smaller number restarts the sequence.
  assign capture = Prime && (!prev_vld || NumberChecked != prev);
  assign gap     = (prev_vld && NumberChecked >= prev) ? NumberChecked - prev : '0;
  assign do_pop  = RdReq && RdValid;

  prime_fifo #(.DEPTH(DEPTH), .W(NW)) u_fifo (
    .core_clk (SysClk),
    .arst_n   (Reset),
    .clr      (Clear),
    .wr_vld   (capture),
    .wr_dat   (NumberChecked),
    .rd_rdy   (RdReq),
    .rd_dat   (RdData),
    .rd_vld   (RdValid),
    .count    (Count),
    .full     (full)
  );

  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset) begin
      prev     <= '0;
      prev_vld <= 1'b0;
      LastGap  <= '0;
      MaxGap   <= '0;
      Overflow <= 1'b0;
    end else if (Clear) begin
      prev     <= '0;
      prev_vld <= 1'b0;
      LastGap  <= '0;
      MaxGap   <= '0;
      Overflow <= 1'b0;
    end else if (capture) begin
      prev     <= NumberChecked;
      prev_vld <= 1'b1;
      LastGap  <= gap;
      if (gap > MaxGap) MaxGap <= gap;
      if (full && !do_pop) Overflow <= 1'b1;
    end
  end

`ifdef PRIME_GAP_TWIN_COUNT_EN
  localparam logic [NW-1:0] TWIN = NW'(TWIN_GAP);

  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset) begin
      TwinCount <= '0;
    end else if (Clear) begin
      TwinCount <= '0;
    end else if (capture && gap == TWIN && TwinCount != 8'hFF) begin
      TwinCount <= TwinCount + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_prime_gap_log.sv
// Scoreboarded bench for prime_gap_log: queue-based reference model, directed scenarios plus random traffic.
module tb_prime_gap_log;
  localparam int DEPTH = 16;
  localparam int NW    = 10;

  logic                   SysClk = 1'b0;
  logic                   rst_n;
  logic                   prime;
  logic [NW-1:0]          num;
  logic                   clr;
  logic                   rd;
  logic [NW-1:0]          RdData;
  logic                   RdValid;
  logic [$clog2(DEPTH):0] Count;
  logic                   Overflow;
  logic [NW-1:0]          LastGap;
  logic [NW-1:0]          MaxGap;
`ifdef PRIME_GAP_TWIN_COUNT_EN
  logic [7:0]             TwinCount;
`endif

  always #5 SysClk = ~SysClk;

  prime_gap_log #(.DEPTH(DEPTH), .NW(NW)) dut (
    .SysClk        (SysClk),
    .Reset         (rst_n),
    .Prime         (prime),
    .NumberChecked (num),
    .Clear         (clr),
    .RdReq         (rd),
    .RdData        (RdData),
    .RdValid       (RdValid),
    .Count         (Count),
    .Overflow      (Overflow),
    .LastGap       (LastGap),
    .MaxGap        (MaxGap)
`ifdef PRIME_GAP_TWIN_COUNT_EN
    ,
    .TwinCount     (TwinCount)
`endif
  );

  int checks = 0;
  int failures = 0;
  int m_q[$];
  int exp_q[$];
  int m_prev, m_lg, m_mg, m_tw;
  bit m_pv, m_ovf;
  int pops_seen = 0;
  int last_pop = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_prime(input int v);
    if (v < 2) return 1'b0;
    for (int d = 2; d * d <= v; d++)
      if (v % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_pv = 1'b0; m_prev = 0; m_lg = 0; m_mg = 0; m_tw = 0; m_ovf = 1'b0;
  endfunction

  // Reference behaviour for one clock edge, expressed on the stored-value list.
  function automatic void model_step(input bit p, input int n, input bit c, input bit r);
    int g;
    bit popped;
    if (c) begin
      model_reset();
      return;
    end
    popped = r && (m_q.size() > 0);
    if (popped) exp_q.push_back(m_q.pop_front());
    if (p && (!m_pv || n != m_prev)) begin
      g = (m_pv && n >= m_prev) ? n - m_prev : 0;
      m_lg = g;
      if (g > m_mg) m_mg = g;
      if (g == 2 && m_tw < 255) m_tw++;
      m_prev = n;
      m_pv = 1'b1;
      if (m_q.size() < DEPTH) m_q.push_back(n);
      else m_ovf = 1'b1;
    end
  endfunction

  task automatic check_state();
    chk("count", int'(Count), m_q.size());
    chk("rdvalid", int'(RdValid), int'(m_q.size() > 0));
    chk("rddata", int'(RdData), (m_q.size() > 0) ? m_q[0] : 0);
    chk("overflow", int'(Overflow), int'(m_ovf));
    chk("lastgap", int'(LastGap), m_lg);
    chk("maxgap", int'(MaxGap), m_mg);
`ifdef PRIME_GAP_TWIN_COUNT_EN
    chk("twincount", int'(TwinCount), m_tw);
`endif
  endtask

  task automatic cycle(input bit p, input int n, input bit c, input bit r);
    prime = p; num = NW'(n); clr = c; rd = r;
    model_step(p, n, c, r);
    @(posedge SysClk); #1;
    check_state();
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 0, 1'b0, 1'b1);
  endtask

  // Monitor: every accepted pop is compared against the next expected value.
  always @(negedge SysClk) begin : monitor
    int e;
    if (rst_n && !clr && rd && RdValid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_pop actual=%0d expected=none at %0t", RdData, $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_rddata", int'(RdData), e);
        last_pop = int'(RdData);
        pops_seen++;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  int p17[17] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59};
  int cur;

  initial begin
    prime = 1'b0; num = '0; clr = 1'b0; rd = 1'b0; rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge SysClk);
    #1;
    check_state();
    chk("reset_count", int'(Count), 0);
    rst_n = 1'b1;

    // Held primes capture once each; twin gaps 3/5 and 5/7.
    foreach (p17[i]) if (i < 4) for (int k = 0; k < 3; k++) cycle(1'b1, p17[i], 1'b0, 1'b0);
    chk("held_count", int'(Count), 4);
    chk("held_lastgap", int'(LastGap), 2);
    chk("held_maxgap", int'(MaxGap), 2);
`ifdef PRIME_GAP_TWIN_COUNT_EN
    chk("held_twin", int'(TwinCount), 2);
`endif
    chk("held_head", int'(RdData), 2);
    drain(4);
    chk("held_last_read", last_pop, 7);

    // Overflow on the 17th distinct prime; stats still advance.
    cycle(1'b0, 0, 1'b1, 1'b0);
    foreach (p17[i]) cycle(1'b1, p17[i], 1'b0, 1'b0);
    chk("ovf_count", int'(Count), 16);
    chk("ovf_flag", int'(Overflow), 1);
    chk("ovf_lastgap", int'(LastGap), 6);
    drain(17);
    chk("ovf_tail", last_pop, 53);

    // Push and pop together while full.
    cycle(1'b0, 0, 1'b1, 1'b0);
    foreach (p17[i]) if (i < 16) cycle(1'b1, p17[i], 1'b0, 1'b0);
    cycle(1'b1, 59, 1'b0, 1'b1);
    chk("full_pp_count", int'(Count), 16);
    chk("full_pp_ovf", int'(Overflow), 0);
    chk("full_pp_head", int'(RdData), 3);
    cycle(1'b1, 61, 1'b0, 1'b0);
    chk("full_drop_ovf", int'(Overflow), 1);
    drain(17);
    chk("full_tail", last_pop, 59);

    // Upstream restart.
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b1, 89, 1'b0, 1'b0);
    cycle(1'b1, 97, 1'b0, 1'b0);
    chk("gap_89_97", int'(LastGap), 8);
    chk("max_89_97", int'(MaxGap), 8);
    cycle(1'b1, 5, 1'b0, 1'b0);
    chk("restart_lastgap", int'(LastGap), 0);
    chk("restart_maxgap", int'(MaxGap), 8);
    chk("restart_count", int'(Count), 3);
    drain(3);

    // Empty reads, async reset mid-run, clear racing a capture.
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b1);
    chk("empty_rd_count", int'(Count), 0);
    cycle(1'b1, 7, 1'b0, 1'b0);
    cycle(1'b1, 11, 1'b0, 1'b0);
    prime = 1'b0; rd = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_count", int'(Count), 0);
    chk("arst_rdvalid", int'(RdValid), 0);
    chk("arst_rddata", int'(RdData), 0);
    chk("arst_lastgap", int'(LastGap), 0);
    chk("arst_maxgap", int'(MaxGap), 0);
    model_reset();
    exp_q.delete();
    #1 rst_n = 1'b1;
    cycle(1'b1, 13, 1'b0, 1'b0);
    chk("post_rst_gap", int'(LastGap), 0);
    chk("post_rst_count", int'(Count), 1);
    cycle(1'b1, 17, 1'b1, 1'b0);
    chk("clr_prime_count", int'(Count), 0);
    cycle(1'b1, 17, 1'b0, 1'b0);
    chk("after_clr_gap", int'(LastGap), 0);
    chk("after_clr_count", int'(Count), 1);

    // Random traffic: holds, small steps, jumps, occasional clears.
    cur = 2;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: ;
        1: cur = (cur + $urandom_range(1, 12)) % 1024;
        2: cur = $urandom_range(0, 1023);
        default: cur = (cur + 2) % 1024;
      endcase
      cycle($urandom_range(0, 3) != 0, cur, $urandom_range(0, 149) == 0,
            $urandom_range(0, 2) == 0);
    end

    // Full upstream stream 2..NumMax with continuous reads.
    cycle(1'b0, 0, 1'b1, 1'b0);
    pops_seen = 0;
    for (int v = 2; v <= 1000; v++) cycle(is_prime(v), v, 1'b0, 1'b1);
    drain(2);
    chk("stream_pops", pops_seen, 168);
    chk("stream_maxgap", int'(MaxGap), 20);
    chk("stream_lastgap", int'(LastGap), 6);
`ifdef PRIME_GAP_TWIN_COUNT_EN
    chk("stream_twin", int'(TwinCount), 35);
`endif

    chk("sb_leftover", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
